// File: rtl/hex_msg_scroller.sv
// hex_msg_scroller: message buffer shown on a row of hexDriver digits as static,
// scrolling (once or looped) or blinking text, one step per prescaler tick.
module hex_msg_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 16,
  parameter int CHAR_W     = 5,
  parameter int TICK_DIV   = 12500000,
  parameter int BLANK_CODE = 21
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]     wr_addr,
  input  logic [CHAR_W-1:0]              wr_char,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_mode,
  input  logic [$clog2(MSG_LEN+1)-1:0]   cmd_len,
  input  logic                           stop,
  output logic [NUM_DIGITS*CHAR_W-1:0]   char_out,
  output logic                           busy,
  output logic                           done
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = $clog2(MSG_LEN + 1);
  localparam int PW = $clog2(MSG_LEN + NUM_DIGITS);
  localparam int IW = $clog2(2 * (MSG_LEN + NUM_DIGITS));
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(BLANK_CODE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STATIC = 3'd1;
  localparam logic [2:0] S_ONCE   = 3'd2;
  localparam logic [2:0] S_LOOP   = 3'd3;
  localparam logic [2:0] S_BON    = 3'd4;
  localparam logic [2:0] S_BOFF   = 3'd5;

  logic [2:0]                    state_q, state_d;
  logic [PW-1:0]                 pos_q, pos_d;
  logic [CW-1:0]                 presc_q, presc_d;
  logic [LW-1:0]                 len_q, len_d, len_cmd;
  logic                          done_q, done_d;
  logic [CHAR_W-1:0]             buf_q [MSG_LEN];
  logic [NUM_DIGITS*CHAR_W-1:0]  char_q, char_d;
  logic                          tick, accept, show;
  logic [PW-1:0]                 pos_last;
  logic [IW-1:0]                 l_full;

  assign cmd_ready = !stop && state_q != S_ONCE;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = state_q != S_IDLE && presc_q == CW'(TICK_DIV - 1);
  assign len_cmd   = cmd_len == '0 ? LW'(1) : cmd_len > LW'(MSG_LEN) ? LW'(MSG_LEN) : cmd_len;
  assign pos_last  = PW'(len_q) + PW'(NUM_DIGITS - 1);
  assign l_full    = IW'(len_q) + IW'(NUM_DIGITS);
  assign show      = state_q != S_IDLE && state_q != S_BOFF;
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;
  assign char_out  = char_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = (state_q == S_IDLE || tick) ? '0 : presc_q + CW'(1);
    len_d   = len_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      pos_d   = '0;
      presc_d = '0;
    end else if (accept) begin
      state_d = 3'(cmd_mode) + 3'd1;
      pos_d   = '0;
      presc_d = '0;
      len_d   = len_cmd;
    end else if (tick) begin
      if (state_q == S_ONCE || state_q == S_LOOP)
        pos_d = pos_q == pos_last ? '0 : pos_q + PW'(1);
      if (state_q == S_ONCE && pos_q == pos_last) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      if (state_q == S_BON)  state_d = S_BOFF;
      if (state_q == S_BOFF) state_d = S_BON;
    end
  end

  // Each digit indexes the virtual string; pos < L and offset < L, so one
  // conditional subtraction is a full modulo-L reduction.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    logic [IW-1:0] raw, idx;
    assign raw = IW'(pos_q) + IW'(NUM_DIGITS - 1 - d);
    assign idx = raw >= l_full ? raw - l_full : raw;
    assign char_d[d*CHAR_W +: CHAR_W] = (show && idx < IW'(len_q)) ? buf_q[idx[AW-1:0]] : BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      presc_q <= '0;
      len_q   <= LW'(1);
      done_q  <= 1'b0;
      char_q  <= {NUM_DIGITS{BLANK}};
      for (int j = 0; j < MSG_LEN; j++) buf_q[j] <= BLANK;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      len_q   <= len_d;
      done_q  <= done_d;
      char_q  <= char_d;
      if (wr_en) buf_q[wr_addr] <= wr_char;
    end
  end
endmodule

// File: tb/tb_hex_msg_scroller.sv
// tb_hex_msg_scroller: directed stimulus queues cycle-stamped expectations; a
// negedge monitor pops and compares them, and matches every done pulse.
module tb_hex_msg_scroller;
  logic        clk = 1'b0;
  logic        rst_n, wr_en, cmd_valid, cmd_ready, stop, busy, done;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_char, cmd_len;
  logic [1:0]  cmd_mode;
  logic [29:0] char_out;

  typedef struct {
    int          c;
    string       n;
    logic [29:0] co;
    logic        b, d, r;
  } exp_t;

  exp_t sq[$];
  int   dq[$];
  exp_t ex;
  int   cyc = 0, n_cmp = 0, n_bad = 0, e, e2;

  localparam logic [29:0] BL = {6{5'd21}};

  hex_msg_scroller #(.NUM_DIGITS(6), .MSG_LEN(16), .CHAR_W(5), .TICK_DIV(4), .BLANK_CODE(21)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .stop(stop), .char_out(char_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [29:0] w(input int a5, a4, a3, a2, a1, a0);
    return {5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic chk(input int c, input string n, input logic [29:0] co, input logic b, d, r);
    sq.push_back('{c, n, co, b, d, r});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input int ch);
    wr_en = 1'b1; wr_addr = 4'(a); wr_char = 5'(ch);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic cmd(input int m, input int l);
    cmd_valid = 1'b1; cmd_mode = 2'(m); cmd_len = 5'(l);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e = cyc;
  endtask

  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].c <= cyc) begin
      ex = sq.pop_front();
      n_cmp++;
      if (ex.c != cyc || char_out !== ex.co || busy !== ex.b || done !== ex.d || cmd_ready !== ex.r) begin
        n_bad++;
        $display("FAIL %s cyc=%0d/%0d got char_out=%h busy=%b done=%b ready=%b want char_out=%h busy=%b done=%b ready=%b",
                 ex.n, cyc, ex.c, char_out, busy, done, cmd_ready, ex.co, ex.b, ex.d, ex.r);
      end
    end
    if (done === 1'b1) begin
      n_cmp++;
      if (dq.size() > 0 && dq[0] == cyc) void'(dq.pop_front());
      else begin
        n_bad++;
        $display("FAIL done_pulse got done=1 at cyc=%0d want no pulse here", cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got cyc=%0d want end of test", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0;
    cmd_valid = 1'b0; cmd_mode = '0; cmd_len = '0; stop = 1'b0;
    @(posedge clk);
    #1;
    chk(cyc, "in_reset", BL, 0, 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk(cyc, "reset_rel", BL, 0, 0, 1);
    chk(cyc + 3, "idle_hold", BL, 0, 0, 1);
    wait_to(cyc + 4);
    wr(0, 16); wr(1, 14); wr(2, 10); wr(3, 17);

    cmd(0, 4);
    chk(e, "static_lag", BL, 1, 0, 1);
    chk(e + 1, "static_w0", w(16, 14, 10, 17, 21, 21), 1, 0, 1);
    chk(e + 20, "static_hold", w(16, 14, 10, 17, 21, 21), 1, 0, 1);
    wait_to(e + 21);

    cmd(1, 4);
    chk(e + 1, "once_p0", w(16, 14, 10, 17, 21, 21), 1, 0, 0);
    chk(e + 4, "once_p0_end", w(16, 14, 10, 17, 21, 21), 1, 0, 0);
    chk(e + 5, "once_p1", w(14, 10, 17, 21, 21, 21), 1, 0, 0);
    chk(e + 9, "once_p2", w(10, 17, 21, 21, 21, 21), 1, 0, 0);
    chk(e + 13, "once_p3", w(17, 21, 21, 21, 21, 21), 1, 0, 0);
    chk(e + 25, "once_p6", w(21, 21, 21, 21, 16, 14), 1, 0, 0);
    chk(e + 37, "once_p9", w(21, 16, 14, 10, 17, 21), 1, 0, 0);
    chk(e + 40, "once_done", w(21, 16, 14, 10, 17, 21), 0, 1, 1);
    dq.push_back(e + 40);
    chk(e + 41, "once_idle", BL, 0, 0, 1);
    wait_to(e + 42);

    cmd(2, 4);
    chk(e + 1, "loop_p0", w(16, 14, 10, 17, 21, 21), 1, 0, 1);
    chk(e + 5, "loop_p1", w(14, 10, 17, 21, 21, 21), 1, 0, 1);
    chk(e + 41, "loop_wrap", w(16, 14, 10, 17, 21, 21), 1, 0, 1);
    chk(e + 45, "loop_p1b", w(14, 10, 17, 21, 21, 21), 1, 0, 1);
    wait_to(e + 46);
    cmd(0, 4);
    chk(e + 1, "preempt_static", w(16, 14, 10, 17, 21, 21), 1, 0, 1);
    chk(e + 9, "preempt_hold", w(16, 14, 10, 17, 21, 21), 1, 0, 1);
    wait_to(e + 10);

    cmd(3, 4);
    chk(e + 1, "blink_on", w(16, 14, 10, 17, 21, 21), 1, 0, 1);
    chk(e + 5, "blink_off", BL, 1, 0, 1);
    chk(e + 9, "blink_on2", w(16, 14, 10, 17, 21, 21), 1, 0, 1);
    chk(e + 13, "blink_off2", BL, 1, 0, 1);
    wait_to(e + 15);
    stop = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_len = 5'd4;
    chk(cyc, "stop_ready", BL, 1, 0, 0);
    @(posedge clk);
    #1;
    stop = 1'b0; cmd_valid = 1'b0;
    chk(cyc, "stop_idle", BL, 0, 0, 1);
    chk(cyc + 1, "stop_blank", BL, 0, 0, 1);
    wait_to(cyc + 2);

    cmd(1, 4);
    chk(e + 5, "once2_p1", w(14, 10, 17, 21, 21, 21), 1, 0, 0);
    wait_to(e + 6);
    rst_n = 1'b0;
    chk(cyc, "rst_async", BL, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk(cyc + 2, "rst_after", BL, 0, 0, 1);
    wait_to(cyc + 3);

    wr(1, 14);
    wr_en = 1'b1; wr_addr = 4'd0; wr_char = 5'd16;
    cmd(0, 0);
    wr_en = 1'b0;
    chk(e + 1, "len0_wr", w(16, 21, 21, 21, 21, 21), 1, 0, 1);
    wait_to(e + 2);
    wr(0, 10);
    chk(cyc + 1, "wr_live", w(10, 21, 21, 21, 21, 21), 1, 0, 1);
    wait_to(cyc + 2);

    cmd(2, 20);
    chk(e + 1, "clamp_p0", w(10, 14, 21, 21, 21, 21), 1, 0, 1);
    chk(e + 85, "clamp_p21", w(21, 10, 14, 21, 21, 21), 1, 0, 1);
    chk(e + 89, "clamp_wrap", w(10, 14, 21, 21, 21, 21), 1, 0, 1);
    wait_to(e + 90);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    chk(cyc + 1, "final_stop", BL, 0, 0, 1);
    wait_to(cyc + 3);

    n_cmp++;
    if (sq.size() != 0 || dq.size() != 0) begin
      n_bad++;
      $display("FAIL drain got pending_checks=%0d pending_done=%0d want 0/0", sq.size(), dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
